// File: rtl/sqr_multi_cycle_struct.sv
// sqr_multi_cycle_struct: shift-add squarer (clk, rst, arg_vld/arg/arg_rdy in, res_vld/res out), one partial product per clock
module sqr_multi_cycle_struct #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arg_vld,
  input  logic [DATA_WIDTH/2-1:0] arg,
  output logic                    arg_rdy,
  output logic                    res_vld,
  output logic [DATA_WIDTH-1:0]   res
);
  localparam int W = DATA_WIDTH / 2;
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mcand, acc, acc_n;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    last = cnt == CW'(W - 1);
    acc_n = acc + (mplier[cnt] ? mcand << cnt : '0);
    arg_rdy = state == IDLE;
    state_n = state == IDLE ? (arg_vld ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      res <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (state == IDLE && arg_vld) begin
        mcand <= DATA_WIDTH'(arg);
        mplier <= arg;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_n;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          res <= acc_n;
          res_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sqr_multi_cycle_struct.sv
// tb_sqr_multi_cycle_struct: table, corner-case and random checks against a countdown reference model
module tb_sqr_multi_cycle_struct;
  localparam int DW = 8;
  localparam int W = DW / 2;
  typedef struct {
    logic [W-1:0]  a;
    logic [DW-1:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst, arg_vld;
  logic [W-1:0] arg;
  logic arg_rdy, res_vld;
  logic [DW-1:0] res;
  int n_vec = 0;
  int n_bad = 0;
  int busy, pulses, cyc;
  logic [W-1:0] pend;
  logic m_vld;
  logic [DW-1:0] m_res;
  vec_t tbl[8];

  sqr_multi_cycle_struct #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg(arg),
    .arg_rdy(arg_rdy), .res_vld(res_vld), .res(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] a);
    rst = r;
    arg_vld = v;
    arg = a;
    @(posedge clk);
    cyc++;
    if (r) begin
      busy = 0;
      m_vld = 1'b0;
      m_res = '0;
    end else begin
      m_vld = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          m_vld = 1'b1;
          m_res = DW'(pend) * DW'(pend);
        end
      end else if (v) begin
        busy = W;
        pend = a;
      end
    end
    #1;
    chk("arg_rdy", 32'(arg_rdy), 32'(busy == 0));
    chk("res_vld", 32'(res_vld), 32'(m_vld));
    chk("res", 32'(res), 32'(m_res));
    if (res_vld === 1'b1) pulses++;
  endtask

  task automatic xact(input logic [W-1:0] a, input logic [DW-1:0] e);
    int p0;
    p0 = pulses;
    cycle(1'b0, 1'b1, a);
    for (int i = 0; i < W; i++) begin
      chk("busy_rdy", 32'(arg_rdy), 32'(0));
      cycle(1'b0, 1'b0, '0);
    end
    chk("tbl_vld", 32'(res_vld), 32'(1));
    chk("tbl_res", 32'(res), 32'(e));
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    chk("tbl_hold", 32'(res), 32'(e));
    chk("tbl_pulses", 32'(pulses - p0), 32'(1));
  endtask

  initial begin
    logic [W-1:0] b2b[3];
    logic [DW-1:0] b2b_e[3];
    int idx, np, tprev;
    tbl[0] = '{a: 4'd0,  e: 8'd0};
    tbl[1] = '{a: 4'd15, e: 8'd225};
    tbl[2] = '{a: 4'd11, e: 8'd121};
    tbl[3] = '{a: 4'd1,  e: 8'd1};
    tbl[4] = '{a: 4'd2,  e: 8'd4};
    tbl[5] = '{a: 4'd7,  e: 8'd49};
    tbl[6] = '{a: 4'd12, e: 8'd144};
    tbl[7] = '{a: 4'd9,  e: 8'd81};
    b2b = '{4'd3, 4'd7, 4'd12};
    b2b_e = '{8'd9, 8'd49, 8'd144};
    pulses = 0;
    cyc = 0;
    busy = 0;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("rst_rdy", 32'(arg_rdy), 32'(1));
    chk("rst_vld", 32'(res_vld), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) xact(tbl[i].a, tbl[i].e);
    idx = 0;
    np = 0;
    tprev = 0;
    for (int i = 0; i < 20 && np < 3; i++) begin
      cycle(1'b0, 1'b1, b2b[idx]);
      if (busy == W && idx < 2) idx++;
      if (res_vld === 1'b1) begin
        chk("b2b_res", 32'(res), 32'(b2b_e[np]));
        if (np > 0) chk("b2b_gap", 32'(cyc - tprev), 32'(W + 1));
        tprev = cyc;
        np++;
      end
    end
    chk("b2b_count", 32'(np), 32'(3));
    cycle(1'b0, 1'b0, '0);
    while (busy != 0 && cyc < 5000) cycle(1'b0, 1'b0, '0);
    pulses = 0;
    cycle(1'b0, 1'b1, 4'd6);
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 4'd5);
    chk("ign_res", 32'(res), 32'(36));
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    chk("ign_pulses", 32'(pulses), 32'(1));
    pulses = 0;
    cycle(1'b0, 1'b1, 4'd13);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("abort_rdy", 32'(arg_rdy), 32'(1));
    chk("abort_res", 32'(res), 32'(0));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    chk("abort_pulses", 32'(pulses), 32'(0));
    xact(4'd2, 8'd4);
    pulses = 0;
    cycle(1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    chk("rst_drop", 32'(pulses), 32'(0));
    pulses = 0;
    for (int a = 0; a < 16; a++) xact(W'(a), DW'(a * a));
    chk("sweep_pulses", 32'(pulses), 32'(16));
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 49) == 0, 1'($urandom), W'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sqr_multi_cycle_struct.md
Name: sqr_multi_cycle_struct

Overview:
- Iterative squarer, the inverse datapath of the single-cycle square-root block.
- Takes a DATA_WIDTH/2-bit unsigned argument and produces its DATA_WIDTH-bit square.
- Uses one shift-add step per clock.
- Sits beside the sqrt datapath. It regenerates squares for round-trip checking and feeds the sqrt block's input stream. It uses a ready/valid handshake on the input side and a one-cycle valid pulse on the output side.

Parameters:
- DATA_WIDTH, 8, result width. Must be even and ≥4. Argument width is W = DATA_WIDTH/2.

Ports:
- clk  input  1  clock. All state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- arg_vld  input  1  argument valid.
- arg  input  W  unsigned argument.
- arg_rdy  output  1  block can accept an argument this cycle.
- res_vld  output  1  one-cycle pulse: res holds a new result.
- res  output  DATA_WIDTH  unsigned square of the last accepted argument.

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-high. rst sampled high at a rising edge sets:
  - state=IDLE, arg_rdy=1, res_vld=0, res=0;
  - bit counter=0, accumulator=0.
- rst has priority over every other input at that edge.
- States: IDLE, CALC.
- IDLE:
  - arg_rdy=1.
  - On an edge with arg_vld=1, capture arg into multiplicand and multiplier registers, clear accumulator and counter, go to CALC.
  - arg_vld=0 → stay in IDLE.
- CALC:
  - arg_rdy=0.
  - Each edge: if multiplier bit[count]=1, accumulator += multiplicand << count (DATA_WIDTH-bit add, no overflow possible). Then count++.
  - On the edge where count==W-1:
    - load res with the final accumulator value, including this step's add;
    - set res_vld=1;
    - count←0, go to IDLE.
  - arg_vld is ignored while in CALC. No capture, no error.
- Latency:
  - Argument accepted at edge k → res_vld high during the cycle following edge k+W.
  - W edges are spent in CALC (4 for the default).
- res_vld:
  - High for exactly one cycle per accepted argument.
  - Deasserts at the next edge unless rst is high. res_vld is 0 after any reset.
- res:
  - Updated only at the result edge or by reset; otherwise holds.
  - Stable while res_vld=1 and afterwards until the next result.
- Throughput:
  - The cycle in which res_vld=1 is an IDLE cycle with arg_rdy=1.
  - A new argument can be accepted at the edge ending that cycle.
  - Steady-state rate: one result per W+1 cycles.
- Arithmetic: unsigned only.
  - Maximum result (2^W−1)^2 fits in DATA_WIDTH bits.
  - arg=0 still takes the full W cycles and yields 0.
- Reset mid-operation:
  - Aborts CALC. No res_vld pulse is produced for the aborted argument; res returns to 0.
  - Block is in IDLE with arg_rdy=1 in the cycle after the reset edge.
- Simultaneous rst=1 and arg_vld=1: the argument is dropped.

Test Plan:
- Reset then arg=0 (W=4) → res_vld pulses once 4 edges after acceptance, res=0x00, arg_rdy low for exactly 4 cycles.
- arg=15 → res=225 (0xE1). arg=11 → res=121 (0x79). arg=1 → res=1. In each case, res holds its value after the res_vld pulse.
- Back-to-back: arg_vld held high with args 3,7,12 presented on each arg_rdy cycle → res 9,49,144 with res_vld pulses spaced 5 cycles apart.
- arg_vld=1 with arg=5 during CALC of arg=6 → only res=36 is produced. The 5 is ignored; arg_rdy=0 throughout.
- rst asserted 2 cycles into CALC of arg=13 → no res_vld pulse, res=0, arg_rdy=1 next cycle. A following arg=2 gives res=4.
- Exhaustive sweep arg=0..15: each res == arg*arg, exactly one res_vld per accepted arg.
